avalon_spi_master: RTL

Parametrised single-clock SPI master with an Avalon-MM slave register interface. It replaces the fixed 32-bit, single-select, mode-0, dual-clock SPI/Avalon pair. It adds runtime-programmable transfer length, CPOL/CPHA, SCLK divider, and multiple slave selects. Sticky done/overrun status and an interrupt complete the feature set. It sits between the Nios/Avalon fabric and external SPI devices.

---
 rtl/avalon_spi_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/avalon_spi_master.sv
// SPI master with an Avalon-MM register slave, single clock domain.
// Registers: 0 TXDATA (W), 1 RXDATA (R), 2 CONTROL (R/W), 3 STATUS (R/W1C).
// Ports: clk/reset (sync, active-high); av_* Avalon-MM slave with a
// combinational read path and wait_request; irq level interrupt;
// sclk/ss_n/mosi/miso SPI pins with runtime CPOL/CPHA, length and divider.
module avalon_spi_master #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SS      = 4,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        av_address,
  input  logic              av_chip_select,
  input  logic              av_read_n,
  input  logic              av_write_n,
  input  logic [31:0]       av_write_data,
  output logic [31:0]       av_read_data,
  output logic              av_wait_request,
  output logic              irq,
  input  logic              miso,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi
);

  localparam int unsigned BW = 6;  // bit-count width (1..32)
  localparam int unsigned HW = 7;  // half-period index width (0..63)

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  state_t            state;
  logic              cpol, cpha, irq_en;
  logic [2:0]        ss_sel;
  logic [4:0]        len_m1;
  logic [7:0]        div;
  logic              busy, done, overrun;
  logic [DATA_W-1:0] rx_data, rx_shift;
  logic [31:0]       tx_data;
  logic [7:0]        cnt;
  logic [HW-1:0]     hp;
  logic [4:0]        ptr;

  // Bus decode
  logic mapped, wr, rd, wr_tx, wr_ctrl, wr_stat, rd_rx, accept, cpol_next;
  assign mapped  = av_chip_select && (av_address[7:2] == 6'd0);
  assign wr      = mapped && !av_write_n;
  assign rd      = mapped && !av_read_n;
  assign wr_tx   = wr && (av_address[1:0] == 2'd0);
  assign wr_ctrl = wr && (av_address[1:0] == 2'd2);
  assign wr_stat = wr && (av_address[1:0] == 2'd3);
  assign rd_rx   = rd && (av_address[1:0] == 2'd1);
  assign accept  = wr_tx && !busy;
  assign av_wait_request = wr_tx && busy;
  assign irq     = done && irq_en;
  assign cpol_next = (wr_ctrl && !busy) ? av_write_data[0] : cpol;

  // Effective transfer length, clamped to DATA_W
  logic [BW-1:0] len_p1, bits;
  logic [4:0]    bits_m1, bits_m2;
  logic [HW-1:0] last_hp;
  assign len_p1  = {1'b0, len_m1} + BW'(1);
  assign bits    = (len_p1 > BW'(DATA_W)) ? BW'(DATA_W) : len_p1;
  assign bits_m1 = 5'(bits - BW'(1));
  assign bits_m2 = 5'(bits - BW'(2));
  assign last_hp = {bits, 1'b0} - HW'(1);

  // SCLK edge events; hp is the SHIFT half-period being left at a tick
  logic tick, lead_edge, trail_edge, drive, sample;
  assign tick       = (cnt == 8'd0);
  assign lead_edge  = tick && ((state == S_LEAD) ||
                      ((state == S_SHIFT) && hp[0] && (hp != last_hp)));
  assign trail_edge = tick && (state == S_SHIFT) && !hp[0];
  // cpha=0 drives on trailing edges except the final one
  assign drive      = cpha ? lead_edge : (trail_edge && (hp != last_hp - HW'(1)));
  assign sample     = cpha ? trail_edge : lead_edge;

  // Read mux
  always_comb begin
    av_read_data = 32'd0;
    if (av_address[7:2] == 6'd0) begin
      case (av_address[1:0])
        2'd1:    av_read_data = 32'(rx_data);
        2'd2:    av_read_data = {div, 3'd0, len_m1, 5'd0, ss_sel, 5'd0, irq_en, cpha, cpol};
        2'd3:    av_read_data = {29'd0, overrun, done, busy};
        default: av_read_data = 32'd0;
      endcase
    end
  end

  // Registers and transfer sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      irq_en   <= 1'b0;
      ss_sel   <= 3'd0;
      len_m1   <= 5'(DATA_W - 1);
      div      <= 8'(DEFAULT_DIV);
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_data  <= 32'd0;
      cnt      <= 8'd0;
      hp       <= '0;
      ptr      <= 5'd0;
      sclk     <= 1'b0;
      ss_n     <= '1;
      mosi     <= 1'b0;
    end else begin
      // Transfer geometry is frozen while busy; irq_en stays writable
      if (wr_ctrl) begin
        irq_en <= av_write_data[2];
        if (!busy) begin
          cpol   <= av_write_data[0];
          cpha   <= av_write_data[1];
          ss_sel <= av_write_data[10:8];
          len_m1 <= av_write_data[20:16];
          div    <= av_write_data[31:24];
        end
      end
      // Software clears first so a same-cycle hardware set below wins
      if (wr_stat) begin
        if (av_write_data[1]) done    <= 1'b0;
        if (av_write_data[2]) overrun <= 1'b0;
      end
      if (rd_rx) done <= 1'b0;

      if (sample) rx_shift <= DATA_W'({rx_shift, miso});
      if (drive) begin
        mosi <= tx_data[ptr];
        ptr  <= ptr - 5'd1;
      end

      case (state)
        S_IDLE: begin
          sclk <= cpol_next;
          if (accept) begin
            state    <= S_LEAD;
            busy     <= 1'b1;
            cnt      <= div;
            hp       <= '0;
            tx_data  <= av_write_data;
            rx_shift <= '0;
            ptr      <= cpha ? bits_m1 : bits_m2;
            if (!cpha) mosi <= av_write_data[bits_m1];
            for (int unsigned i = 0; i < NUM_SS; i++)
              ss_n[i] <= (ss_sel != 3'(i));
          end
        end
        S_LEAD: begin
          if (!tick) cnt <= cnt - 8'd1;
          else begin
            cnt   <= div;
            sclk  <= ~sclk;
            hp    <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!tick) cnt <= cnt - 8'd1;
          else begin
            cnt <= div;
            if (hp == last_hp) state <= S_TRAIL;
            else begin
              sclk <= ~sclk;
              hp   <= hp + HW'(1);
            end
          end
        end
        S_TRAIL: begin
          if (!tick) cnt <= cnt - 8'd1;
          else begin
            cnt     <= div;
            state   <= S_GAP;
            ss_n    <= '1;
            rx_data <= rx_shift;
            done    <= 1'b1;
            overrun <= overrun | done;
          end
        end
        S_GAP: begin
          if (!tick) cnt <= cnt - 8'd1;
          else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
